// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: shifts one byte per request onto txd as an async UART frame
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   i_tx[7:0]         byte to send, sampled on the acceptance cycle only
//   i_tx_start        level request, held by the controller until o_tx_start_clear
//   o_tx_busy         high from the cycle after acceptance through the clear cycle
//   o_tx_start_clear  one-cycle pulse after the last stop bit
//   o_txd             serial line, idles high
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 434,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i_tx,
   input  logic       i_tx_start,
   output logic       o_tx_busy,
   output logic       o_tx_start_clear,
   output logic       o_txd
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   // Stop bits reuse the data bit index; anything above one stop bit means two.
   localparam logic [2:0] LAST_STOP = (STOP_BITS > 1) ? 3'd1 : 3'd0;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEAR} state_t;
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic [7:0]    shift_q;
   logic          par_q;
   logic          bit_end;
   assign bit_end = cnt_q == LAST;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         cnt_q            <= '0;
         idx_q            <= '0;
         shift_q          <= '0;
         par_q            <= 1'b0;
         o_tx_busy        <= 1'b0;
         o_tx_start_clear <= 1'b0;
         o_txd            <= 1'b1;
      end else begin
         o_tx_start_clear <= 1'b0;
         // Baud counter runs only while a bit is on the line and wraps at each bit boundary.
         cnt_q <= (state_q inside {START, DATA, PARITY, STOP} && !bit_end) ? cnt_q + 1'b1 : '0;
         case (state_q)
            IDLE: begin
               if (i_tx_start && !o_tx_start_clear) begin
                  shift_q   <= i_tx;
                  par_q     <= ^i_tx ^ PARITY_ODD;
                  state_q   <= START;
                  o_txd     <= 1'b0;
                  o_tx_busy <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  state_q <= DATA;
                  idx_q   <= '0;
                  o_txd   <= shift_q[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (idx_q == 3'd7) begin
                     idx_q   <= '0;
                     state_q <= PARITY_EN ? PARITY : STOP;
                     o_txd   <= PARITY_EN ? par_q : 1'b1;
                  end else begin
                     // Next bit is presented from shift_q[1] while the register shifts under it.
                     idx_q   <= idx_q + 1'b1;
                     shift_q <= shift_q >> 1;
                     o_txd   <= shift_q[1];
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state_q <= STOP;
                  o_txd   <= 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (idx_q == LAST_STOP) begin
                     idx_q            <= '0;
                     state_q          <= CLEAR;
                     o_tx_start_clear <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            CLEAR: begin
               state_q   <= IDLE;
               o_tx_busy <= 1'b0;
            end
            default: begin
               state_q   <= IDLE;
               o_tx_busy <= 1'b0;
               o_txd     <= 1'b1;
            end
         endcase
      end
   end
endmodule
